lift_mod_scaler: RTL and testbench
==================================

# lift_mod_scaler

Parametrised successor of the lift/scale first stage. It streams NUM_MOD residues and matching fixed-point constants from external RAM/ROM, and accumulates their products in a multiply-accumulate pipeline. It then produces a floor or centrally-lifted (rounded) quotient, together with a central-lift flag. It sits between the residue RAM banks and the final-adjust/mod-q stages, and uses a valid/ready result handshake instead of a fixed-delay go signal.

## Interface
- NUM_MOD, 6: residues per coefficient; 2..16.
- RES_W, 30: residue width.
- CONST_W, 64: constant width, unsigned fixed point.
- FRAC_W, 60: fractional bits of the constant; 1 ≤ FRAC_W < CONST_W.
- Derived: ADDR_W = clog2(NUM_MOD); ACC_W = RES_W+CONST_W+ADDR_W; QUOT_W = ACC_W−FRAC_W.

Ports:
- CLK in 1: clock.
- RST in 1: reset, synchronous, active-high.
- START in 1: begin one coefficient; sampled only in IDLE.
- MODE in 1: 0 = floor, 1 = round-to-nearest (central lift); latched at START.
- RD_EN out 1: read strobe to residue RAM and constant ROM.
- RD_ADDR out ADDR_W: residue/constant index.
- D_IN in RES_W: residue; valid the cycle after RD_EN.
- C_IN in CONST_W: constant; same latency as D_IN.
- BUSY out 1: high in every state except IDLE.
- VALID out 1: result available; held until accepted.
- READY in 1: downstream accept.
- QUOTIENT out QUOT_W: scaled result.
- CF_OUT out 1: 1 when a round-up occurred.
- CF_CNT out 16: central-lift event count (see Configuration).

## Operation
- FSM states: IDLE, READ, DRAIN, ROUND, HOLD.
- IDLE: on START, latch MODE, clear the accumulator, go to READ.
- READ: assert RD_EN for NUM_MOD consecutive cycles, with RD_ADDR = 0..NUM_MOD−1. The address counter wraps to 0 after the last read. Then go to DRAIN.
- DRAIN: 2 cycles, one for the product register and one for the final accumulate. Then go to ROUND.
- ROUND, MODE=0: QUOTIENT = ACC[ACC_W−1:FRAC_W], CF_OUT = 0.
- ROUND, MODE=1: r = ACC[FRAC_W−1]; QUOTIENT = (ACC >> FRAC_W) + r, truncated mod 2^QUOT_W; CF_OUT = r.
- After ROUND, go to HOLD.
- HOLD: VALID=1, and QUOTIENT/CF_OUT are stable. When VALID&&READY, return to IDLE.
- Arithmetic: the product is RES_W×CONST_W, unsigned and full width. The accumulator is ACC_W bits and cannot overflow for any input values.
- A START outside IDLE is ignored and never queued.
- RST in any state: go to IDLE and discard the partial accumulation.

## Timing
- Cycle 0: START sampled in IDLE.
- Cycles 1..NUM_MOD: RD_EN high.
- RD_EN at cycle k: D_IN/C_IN captured into the product register at the end of cycle k+1; accumulated at the end of cycle k+2.
- ROUND occupies cycle NUM_MOD+3.
- VALID rises at cycle NUM_MOD+4 (cycle 10 at defaults).
- The earliest next START is sampled the cycle after the accepting VALID&&READY cycle.
- The minimum coefficient period is NUM_MOD+5 cycles.
- Reset values: RD_EN=0, RD_ADDR=0, BUSY=0, VALID=0, QUOTIENT=0, CF_OUT=0, CF_CNT=0.

## Configuration
- LIFT_MOD_SCALER_CF_CNT_EN defined: CF_CNT is a 16-bit counter.
  - It increments on each VALID&&READY with CF_OUT=1.
  - It saturates at 0xFFFF and is cleared only by RST.
- LIFT_MOD_SCALER_CF_CNT_EN undefined: the CF_CNT port is still present and tied to 0, and no counter logic is generated.

## Structure
- Shared package lift_mod_pkg holds:
  - the FSM state encoding;
  - the clog2 function;
  - derived-width helpers for ADDR_W, ACC_W and QUOT_W;
  - the DRAIN length constant (2).
- Sub-module lift_mac_pipe holds the product register and accumulator. Its ports are clear, in_valid, D_IN, C_IN and acc. The FSM, address counter, rounding logic and handshake stay in the top level.

## Test plan
All scenarios use default parameters unless stated.
- Floor vs round: D_IN=1 at address 0 and 0 elsewhere; C_IN=2^59 (0.5).
  - MODE=0 → QUOTIENT=0, CF_OUT=0.
  - MODE=1 → QUOTIENT=1, CF_OUT=1.
- Exact sum: all D_IN=1, C_IN=2^60 (1.0), MODE=1 → QUOTIENT=6, CF_OUT=0, VALID at cycle 10.
- Backpressure: READY=0 for 20 cycles after VALID.
  - VALID and QUOTIENT stay stable and BUSY stays 1.
  - A START pulse during the stall is ignored.
  - READY=1 → IDLE on the next cycle.
- Max operands: all D_IN=2^30−1, C_IN=2^64−1, MODE=0 → QUOTIENT = floor(6·(2^30−1)·(2^64−1)/2^60), with no accumulator wrap.
- Reset mid-operation: RST asserted at cycle 4 of READ.
  - All outputs return to reset values next cycle.
  - A following clean START gives the correct result with no residue from the aborted run.
- CF counter with LIFT_MOD_SCALER_CF_CNT_EN defined: 3 accepted round-ups plus 1 non-round-up → CF_CNT=3. With the macro undefined, CF_CNT=0.

Source files
------------

// File: rtl/lift_mod_pkg.sv
// rtl/lift_mod_pkg.sv - shared FSM encoding, width helpers and constants for lift_mod_scaler
package lift_mod_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    ROUND = 3'd3,
    HOLD  = 3'd4
  } state_t;

  // Product register stage plus final accumulate stage
  localparam int DRAIN_LEN = 2;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int addr_w_of(input int num_mod);
    return clog2(num_mod);
  endfunction

  // Headroom of ADDR_W bits lets NUM_MOD full-scale products sum without wrap
  function automatic int acc_w_of(input int res_w, input int const_w, input int num_mod);
    return res_w + const_w + addr_w_of(num_mod);
  endfunction

  function automatic int quot_w_of(input int res_w, input int const_w, input int frac_w,
                                   input int num_mod);
    return acc_w_of(res_w, const_w, num_mod) - frac_w;
  endfunction

endpackage

// File: rtl/lift_mac_pipe.sv
// rtl/lift_mac_pipe.sv - product register and accumulator for the lift/scale MAC
module lift_mac_pipe
  import lift_mod_pkg::*;
#(
  parameter int RES_W   = 30,
  parameter int CONST_W = 64,
  parameter int ADDR_W  = 3,
  localparam int PROD_W = RES_W + CONST_W,
  localparam int ACC_W  = PROD_W + ADDR_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [RES_W-1:0]   D_IN,
  input  logic [CONST_W-1:0] C_IN,
  output logic [ACC_W-1:0]   acc
);

  logic [PROD_W-1:0] r_prod;
  logic              r_prod_vld;
  logic [ACC_W-1:0]  r_acc;

  // Stage 1: register the full-width unsigned product of the incoming operands
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
    end else begin
      r_prod_vld <= in_valid;
      if (in_valid) begin
        r_prod <= PROD_W'(D_IN) * PROD_W'(C_IN);
      end
    end
  end

  // Stage 2: add each valid product into the accumulator
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      r_acc <= '0;
    end else if (r_prod_vld) begin
      r_acc <= r_acc + {{ADDR_W{1'b0}}, r_prod};
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/lift_mod_scaler.sv
// rtl/lift_mod_scaler.sv - streamed MAC lift/scale stage with floor/round and optional LIFT_MOD_SCALER_CF_CNT_EN counter
module lift_mod_scaler
  import lift_mod_pkg::*;
#(
  parameter int NUM_MOD = 6,
  parameter int RES_W   = 30,
  parameter int CONST_W = 64,
  parameter int FRAC_W  = 60,
  localparam int ADDR_W = addr_w_of(NUM_MOD),
  localparam int ACC_W  = acc_w_of(RES_W, CONST_W, NUM_MOD),
  localparam int QUOT_W = quot_w_of(RES_W, CONST_W, FRAC_W, NUM_MOD)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               MODE,
  output logic               RD_EN,
  output logic [ADDR_W-1:0]  RD_ADDR,
  input  logic [RES_W-1:0]   D_IN,
  input  logic [CONST_W-1:0] C_IN,
  output logic               BUSY,
  output logic               VALID,
  input  logic               READY,
  output logic [QUOT_W-1:0]  QUOTIENT,
  output logic               CF_OUT,
  output logic [15:0]        CF_CNT
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_MOD - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'(DRAIN_LEN - 1);

  state_t              r_state;
  state_t              w_next;
  logic                w_clear;
  logic                w_rd_en;
  logic                w_busy;
  logic                w_valid;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_drain;
  logic                r_mode;
  logic                r_rd_vld;
  logic [QUOT_W-1:0]   r_quot;
  logic                r_cf;
  logic [ACC_W-1:0]    w_acc;
  logic [QUOT_W-1:0]   w_int;
  logic                w_round_bit;
  logic                w_cf;
  logic [QUOT_W-1:0]   w_quot;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    w_rd_en = 1'b0;
    w_busy  = 1'b1;
    w_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (START) begin
          w_next  = READ;
          w_clear = 1'b1;
        end
      end
      READ: begin
        w_rd_en = 1'b1;
        if (r_addr == LAST_ADDR) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (r_drain == DRAIN_LAST) begin
          w_next = ROUND;
        end
      end
      ROUND: begin
        w_next = HOLD;
      end
      HOLD: begin
        w_valid = 1'b1;
        if (READY) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
        w_busy = 1'b0;
      end
    endcase
  end

  // Read address walks 0..NUM_MOD-1 during READ and wraps back to 0
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr <= '0;
    end else if (r_state == READ) begin
      if (r_addr == LAST_ADDR) begin
        r_addr <= '0;
      end else begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  // Counts the cycles spent letting the MAC pipeline empty
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_drain <= '0;
    end else if (r_state == DRAIN) begin
      r_drain <= r_drain + 1'b1;
    end else begin
      r_drain <= '0;
    end
  end

  // Mode latch and one-cycle delay of the read strobe to match RAM latency
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mode   <= 1'b0;
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_en;
      if (r_state == IDLE && START) begin
        r_mode <= MODE;
      end
    end
  end

  lift_mac_pipe #(
    .RES_W   (RES_W),
    .CONST_W (CONST_W),
    .ADDR_W  (ADDR_W)
  ) u_mac (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (w_clear),
    .in_valid (r_rd_vld),
    .D_IN     (D_IN),
    .C_IN     (C_IN),
    .acc      (w_acc)
  );

  // Integer part plus, in central-lift mode, the top fraction bit as round-up
  assign w_int       = w_acc[ACC_W-1:FRAC_W];
  assign w_round_bit = w_acc[FRAC_W-1];
  assign w_cf        = r_mode & w_round_bit;
  assign w_quot      = w_int + QUOT_W'(w_cf);

  // The lower fraction bits never influence a floor or round-half-up result
  if (FRAC_W > 1) begin : g_frac_lo
    logic w_unused_frac;
    assign w_unused_frac = ^w_acc[FRAC_W-2:0];
  end

  // Capture the result in ROUND so it stays stable through HOLD
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_quot <= '0;
      r_cf   <= 1'b0;
    end else if (r_state == ROUND) begin
      r_quot <= w_quot;
      r_cf   <= w_cf;
    end
  end

  assign RD_EN    = w_rd_en;
  assign RD_ADDR  = r_addr;
  assign BUSY     = w_busy;
  assign VALID    = w_valid;
  assign QUOTIENT = r_quot;
  assign CF_OUT   = r_cf;

`ifdef LIFT_MOD_SCALER_CF_CNT_EN
  logic [15:0] r_cf_cnt;

  // Saturating count of accepted results that were rounded up
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cf_cnt <= '0;
    end else if (w_valid && READY && r_cf && (r_cf_cnt != 16'hFFFF)) begin
      r_cf_cnt <= r_cf_cnt + 16'd1;
    end
  end

  assign CF_CNT = r_cf_cnt;
`else
  assign CF_CNT = 16'd0;
`endif

endmodule

// File: tb/tb_lift_mod_scaler.sv
// tb/tb_lift_mod_scaler.sv - self-checking bench for lift_mod_scaler
module tb_lift_mod_scaler;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        MODE;
  logic        RD_EN;
  logic [2:0]  RD_ADDR;
  logic [29:0] D_IN;
  logic [63:0] C_IN;
  logic        BUSY;
  logic        VALID;
  logic        READY;
  logic [36:0] QUOTIENT;
  logic        CF_OUT;
  logic [15:0] CF_CNT;

  int n_chk  = 0;
  int n_fail = 0;

  logic [29:0] mem_d [6];
  logic [63:0] mem_c [6];
  logic [36:0] exp_q  = '0;
  logic        exp_cf = 1'b0;
  int          cf_model = 0;

  lift_mod_scaler dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .MODE     (MODE),
    .RD_EN    (RD_EN),
    .RD_ADDR  (RD_ADDR),
    .D_IN     (D_IN),
    .C_IN     (C_IN),
    .BUSY     (BUSY),
    .VALID    (VALID),
    .READY    (READY),
    .QUOTIENT (QUOTIENT),
    .CF_OUT   (CF_OUT),
    .CF_CNT   (CF_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Residue RAM / constant ROM with one cycle read latency
  always @(posedge CLK) begin
    if (RD_EN) begin
      D_IN <= mem_d[RD_ADDR];
      C_IN <= mem_c[RD_ADDR];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  // Exact-arithmetic reference: dot product, then floor or round-half-up
  function automatic logic [36:0] model_q(input logic m);
    logic [127:0] s;
    logic [127:0] q;
    s = '0;
    for (int i = 0; i < 6; i++) s = s + 128'(mem_d[i]) * 128'(mem_c[i]);
    q = s / (128'd1 << 60);
    if (m && ((s % (128'd1 << 60)) >= (128'd1 << 59))) q = q + 128'd1;
    return q[36:0];
  endfunction

  function automatic logic model_cf(input logic m);
    logic [127:0] s;
    s = '0;
    for (int i = 0; i < 6; i++) s = s + 128'(mem_d[i]) * 128'(mem_c[i]);
    return m && ((s % (128'd1 << 60)) >= (128'd1 << 59));
  endfunction

  task automatic set_data(input logic [29:0] d0, input logic [29:0] drest, input logic [63:0] c);
    for (int i = 0; i < 6; i++) begin
      mem_d[i] = (i == 0) ? d0 : drest;
      mem_c[i] = c;
    end
  endtask

  // Result checker: whenever a result is offered it must match the model
  always @(negedge CLK) begin
    if (!RST && VALID) begin
      chk("model_q", 64'(QUOTIENT), 64'(exp_q));
      chk("model_cf", 64'(CF_OUT), 64'(exp_cf));
    end
  end

  task automatic run_coef(input logic m, input logic [36:0] lit_q, input logic lit_cf,
                          input int stall, input string nm);
    int cyc;
    exp_q  = model_q(m);
    exp_cf = model_cf(m);
    @(negedge CLK);
    START = 1'b1;
    MODE  = m;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    MODE  = ~m;
    cyc = 1;
    while (!VALID && cyc < 100) begin
      chk({nm, "_rd_en"}, 64'(RD_EN), 64'(cyc >= 1 && cyc <= 6));
      if (cyc >= 1 && cyc <= 6) chk({nm, "_rd_addr"}, 64'(RD_ADDR), 64'(cyc - 1));
      chk({nm, "_busy"}, 64'(BUSY), 64'd1);
      @(negedge CLK);
      cyc++;
    end
    chk({nm, "_valid_cycle"}, 64'(cyc), 64'd10);
    chk({nm, "_q"}, 64'(QUOTIENT), 64'(lit_q));
    chk({nm, "_cf"}, 64'(CF_OUT), 64'(lit_cf));
    for (int s = 0; s < stall; s++) begin
      chk({nm, "_stall_valid"}, 64'(VALID), 64'd1);
      chk({nm, "_stall_busy"}, 64'(BUSY), 64'd1);
      chk({nm, "_stall_q"}, 64'(QUOTIENT), 64'(lit_q));
      START = (s == 5);
      @(negedge CLK);
    end
    START = 1'b0;
    READY = 1'b1;
    @(posedge CLK);
    if (exp_cf) cf_model++;
    @(negedge CLK);
    READY = 1'b0;
    chk({nm, "_idle_busy"}, 64'(BUSY), 64'd0);
    chk({nm, "_idle_valid"}, 64'(VALID), 64'd0);
    if (stall > 0) begin
      @(negedge CLK);
      chk({nm, "_start_ignored"}, 64'(BUSY), 64'd0);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_rd_en"}, 64'(RD_EN), 64'd0);
    chk({nm, "_rd_addr"}, 64'(RD_ADDR), 64'd0);
    chk({nm, "_busy"}, 64'(BUSY), 64'd0);
    chk({nm, "_valid"}, 64'(VALID), 64'd0);
    chk({nm, "_q"}, 64'(QUOTIENT), 64'd0);
    chk({nm, "_cf"}, 64'(CF_OUT), 64'd0);
    chk({nm, "_cf_cnt"}, 64'(CF_CNT), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    cf_model = 0;
  endtask

  initial begin
    RST   = 1'b1;
    START = 1'b0;
    MODE  = 1'b0;
    READY = 1'b0;
    D_IN  = '0;
    C_IN  = '0;
    set_data(30'd0, 30'd0, 64'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b0;

    // One half: floor drops it, central lift rounds it up
    set_data(30'd1, 30'd0, 64'h0800_0000_0000_0000);
    run_coef(1'b0, 37'd0, 1'b0, 0, "half_floor");
    run_coef(1'b1, 37'd1, 1'b1, 0, "half_round");

    // Six times 1.0 is exact: no round-up
    set_data(30'd1, 30'd1, 64'h1000_0000_0000_0000);
    run_coef(1'b1, 37'd6, 1'b0, 0, "exact_sum");

    // Held result under 20 cycles of backpressure, stray START ignored
    run_coef(1'b0, 37'd6, 1'b0, 20, "backpressure");

    // Full-scale operands: floor(6*(2^30-1)*(2^64-1)/2^60) = 6*2^34 - 97
    set_data(30'h3FFF_FFFF, 30'h3FFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    run_coef(1'b0, 37'd103079215007, 1'b0, 0, "max_ops");

    // Abort at the fourth read cycle, then a clean run must be unaffected
    @(negedge CLK);
    START = 1'b1;
    MODE  = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    chk("abort_rd_en_c4", 64'(RD_EN), 64'd1);
    chk("abort_addr_c4", 64'(RD_ADDR), 64'd3);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("abort");
    RST = 1'b0;
    cf_model = 0;
    set_data(30'd1, 30'd1, 64'h1000_0000_0000_0000);
    run_coef(1'b1, 37'd6, 1'b0, 0, "after_abort");

    // Three accepted round-ups and one plain result
    do_reset();
    set_data(30'd1, 30'd0, 64'h0800_0000_0000_0000);
    run_coef(1'b1, 37'd1, 1'b1, 0, "cf1");
    run_coef(1'b1, 37'd1, 1'b1, 0, "cf2");
    run_coef(1'b0, 37'd0, 1'b0, 0, "cf_none");
    run_coef(1'b1, 37'd1, 1'b1, 0, "cf3");
`ifdef LIFT_MOD_SCALER_CF_CNT_EN
    chk("cf_cnt_model", 64'(CF_CNT), 64'(cf_model));
    chk("cf_cnt_three", 64'(CF_CNT), 64'd3);
`else
    chk("cf_cnt_tied", 64'(CF_CNT), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
